// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_defines
// Description : Shared RISC-V execute-stage types: ALU control encoding,
//               divider sequencer states and divide-class helper predicates.
// Revision    : 1.0 - initial release with divide-class additions
// ============================================================================
package riscv_defines;

    // Decoded ALU operation selector shared by the ALU and the divider
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_MUL  = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_DIVU = 4'd13,
        ALU_REM  = 4'd14,
        ALU_REMU = 4'd15
    } alucontrol_t;

    // Divider sequencer states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // True for the four operations the divider handles
    function automatic logic is_div_op(input alucontrol_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    // True for the two-complement (signed) divide-class operations
    function automatic logic is_signed_div_op(input alucontrol_t op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    // True when the remainder, not the quotient, is returned
    function automatic logic is_rem_op(input alucontrol_t op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
//               Shifts {rem, quo} left by one, trial-subtracts the divisor
//               in XLEN+1 bits and keeps the difference when nonnegative.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import riscv_defines::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shifted_rem;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    // Partial remainder after the shift; the extra top bit holds the bit
    // shifted out of rem so the trial subtraction never loses magnitude.
    assign w_shifted_rem = {i_rem, i_quo[XLEN-1]};
    assign w_diff        = w_shifted_rem - {1'b0, i_divisor};
    assign w_fits        = ~w_diff[XLEN];

    // Restore on a negative trial result, otherwise keep the difference
    always_comb begin
        o_rem = w_fits ? w_diff[XLEN-1:0] : w_shifted_rem[XLEN-1:0];
        o_quo = {i_quo[XLEN-2:0], w_fits};
    end

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU).
//               Valid/ready request side, registered result side, XLEN-step
//               restoring division with sign fixup and special-case bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer
    import riscv_defines::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  alucontrol_t       in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int              CNT_W       = $clog2(XLEN);
    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [XLEN-1:0]  c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_count;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_divisor;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_tag;
    logic               r_out_valid;

    logic               w_signed;
    logic               w_is_rem;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic               w_div_zero;
    logic               w_overflow;
    logic [XLEN-1:0]    w_special_result;
    logic [XLEN-1:0]    w_next_rem;
    logic [XLEN-1:0]    w_next_quo;
    logic [XLEN-1:0]    w_quo_final;
    logic [XLEN-1:0]    w_rem_final;

    // Request decode, operand magnitudes and special-case resolution
    always_comb begin
        w_signed   = is_signed_div_op(in_op);
        w_is_rem   = is_rem_op(in_op);
        w_a_neg    = w_signed & in_a[XLEN-1];
        w_b_neg    = w_signed & in_b[XLEN-1];
        // The most negative value negates to itself, which is its correct
        // unsigned magnitude.
        w_abs_a    = w_a_neg ? -in_a : in_a;
        w_abs_b    = w_b_neg ? -in_b : in_b;
        w_div_zero = (in_b == '0);
        w_overflow = w_signed && (in_a == c_int_min) && (in_b == '1);
        if (w_div_zero) begin
            w_special_result = w_is_rem ? in_a : '1;
        end else begin
            w_special_result = w_is_rem ? '0 : in_a;
        end
    end

    div_step #(
        .XLEN      (XLEN)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_next_rem),
        .o_quo     (w_next_quo)
    );

    // Sign fixup applied to the outcome of the final iteration
    always_comb begin
        w_quo_final = r_neg_q ? -w_next_quo : w_next_quo;
        w_rem_final = r_neg_r ? -w_next_rem : w_next_rem;
    end

    // Sequencer FSM, operand latching, iteration and result registration
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= DIV_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
            r_tag       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= DIV_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (in_valid) begin
                        r_tag    <= in_tag;
                        r_is_rem <= w_is_rem;
                        if (w_div_zero || w_overflow) begin
                            r_result    <= w_special_result;
                            r_out_valid <= 1'b1;
                            r_state     <= DIV_DONE;
                        end else begin
                            r_rem     <= '0;
                            r_quo     <= w_abs_a;
                            r_divisor <= w_abs_b;
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                            r_count   <= '0;
                            r_state   <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem   <= w_next_rem;
                    r_quo   <= w_next_quo;
                    r_count <= r_count + c_cnt_one;
                    if (r_count == c_last_step) begin
                        r_result    <= r_is_rem ? w_rem_final : w_quo_final;
                        r_out_valid <= 1'b1;
                        r_state     <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= DIV_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= DIV_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == DIV_IDLE);
    assign busy       = (r_state != DIV_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_tag    = r_tag;

    // Only divide-class operations may be presented to this unit
    a_op_legal : assert property (@(posedge clk) disable iff (reset)
        (in_valid && in_ready) |-> is_div_op(in_op));

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Self-checking bench for div_sequencer. A cycle-level
//               behavioural model predicts handshake/result outputs from
//               plain arithmetic; directed vectors carry literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;
    import riscv_defines::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    alucontrol_t       in_op;
    logic [XLEN-1:0]   in_a;
    logic [XLEN-1:0]   in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    div_sequencer #(
        .XLEN       (XLEN),
        .TAG_W      (TAG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic is_special(input alucontrol_t op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) ||
               (((op == ALU_DIV) || (op == ALU_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model_result(input alucontrol_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (is_special(op, a, b)) begin
            q = a;
            r = 32'h0;
        end else if (op == ALU_DIV || op == ALU_REM) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op == ALU_REM || op == ALU_REMU) ? r : q;
    endfunction

    // 0 = waiting for a request, 1 = dividing, 2 = result held
    int          m_phase   = 0;
    int          m_left    = 0;
    bit          m_zero    = 1'b1;
    bit          m_started = 1'b0;
    logic [31:0] m_result  = '0;
    logic [4:0]  m_tag     = '0;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (reset) begin
            m_phase = 0;
            m_zero  = 1'b1;
        end else if (flush) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_zero   = 1'b0;
                    m_tag    = in_tag;
                    m_result = model_result(in_op, in_a, in_b);
                    if (is_special(in_op, in_a, in_b)) begin
                        m_phase = 2;
                    end else begin
                        m_phase = 1;
                        m_left  = XLEN;
                    end
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(posedge clk) begin
        #1;
        if (m_started) begin
            chk("cyc_in_ready", in_ready, m_phase == 0);
            chk("cyc_busy", busy, m_phase != 0);
            chk("cyc_out_valid", out_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("cyc_out_result", out_result, m_result);
                chk("cyc_out_tag", out_tag, m_tag);
            end else if (m_zero) begin
                chk("cyc_reset_result", out_result, 0);
                chk("cyc_reset_tag", out_tag, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input alucontrol_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int waits);
        bit acc;
        bit ok;
        ok       = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 100; i++) begin
            acc = in_ready;
            @(negedge clk);
            waits++;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            failures++;
            checks++;
            $display("FAIL accept_timeout: got=not_accepted expected=accepted");
        end
    endtask

    task automatic collect(input string name, input logic [31:0] exp, input logic [4:0] tag,
                           input int exp_cycles);
        int lat;
        int busy_n;
        bit idle_seen;
        lat       = 0;
        busy_n    = 0;
        idle_seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) busy_n++;
            if (out_valid && lat == 0) begin
                lat = i;
                chk({name, "_result"}, out_result, exp);
                chk({name, "_tag"}, out_tag, tag);
            end
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_idle_seen"}, idle_seen, 1);
        chk({name, "_latency"}, lat, exp_cycles);
        chk({name, "_busy_cycles"}, busy_n, exp_cycles);
    endtask

    task automatic run_op(input string name, input alucontrol_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                          input int exp_cycles);
        int w;
        issue(op, a, b, tag, w);
        collect(name, exp, tag, exp_cycles);
    endtask

    initial begin
        int w;
        int rises;
        bit seen;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = ALU_DIVU;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);

        run_op("divu_100_7",  ALU_DIVU, 32'd100,        32'd7,          5'd1,  32'd14,         33);
        run_op("remu_100_7",  ALU_REMU, 32'd100,        32'd7,          5'd2,  32'd2,          33);
        run_op("div_m7_2",    ALU_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33);
        run_op("rem_m7_2",    ALU_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  33);
        run_op("div_7_m2",    ALU_DIV,  32'd7,          32'hFFFF_FFFE,  5'd5,  32'hFFFF_FFFD,  33);
        run_op("rem_7_m2",    ALU_REM,  32'd7,          32'hFFFF_FFFE,  5'd6,  32'd1,          33);
        run_op("div_ovf",     ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  1);
        run_op("rem_ovf",     ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1);
        run_op("divu_5_0",    ALU_DIVU, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  1);
        run_op("rem_5_0",     ALU_REM,  32'd5,          32'd0,          5'd12, 32'd5,          1);
        run_op("div_m5_0",    ALU_DIV,  32'hFFFF_FFFB,  32'd0,          5'd13, 32'hFFFF_FFFF,  1);
        run_op("divu_max_1",  ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd14, 32'hFFFF_FFFF,  33);
        run_op("remu_max_16", ALU_REMU, 32'hFFFF_FFFF,  32'h10,         5'd15, 32'hF,          33);
        run_op("div_min_2",   ALU_DIV,  32'h8000_0000,  32'd2,          5'd16, 32'hC000_0000,  33);
        run_op("div_min_min", ALU_DIV,  32'h8000_0000,  32'h8000_0000,  5'd17, 32'd1,          33);
        run_op("rem_m100_7",  ALU_REM,  32'hFFFF_FF9C,  32'd7,          5'd18, 32'hFFFF_FFFE,  33);

        // Result held while the consumer stalls, then back-to-back request
        out_ready = 1'b0;
        issue(ALU_DIVU, 32'd1000, 32'd10, 5'd9, w);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("hold_valid_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_result", out_result, 32'd100);
            chk("hold_tag", out_tag, 5'd9);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        issue(ALU_REMU, 32'd1000, 32'd7, 5'd10, w);
        chk("b2b_accept_waits", w, 2);
        collect("b2b_remu", 32'd6, 5'd10, 33);

        // Flush during iteration 15: nothing is produced
        issue(ALU_DIV, 32'd12345, 32'hFFFF_FFFD, 5'd19, w);
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_busy", busy, 0);
        chk("flush_out_valid", out_valid, 0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) rises++;
            @(negedge clk);
        end
        chk("flush_no_result", rises, 0);

        // Reset in the middle of a calculation returns every output to reset values
        run_op("divu_9_2", ALU_DIVU, 32'd9, 32'd2, 5'd20, 32'd4, 33);
        issue(ALU_DIVU, 32'd77, 32'd3, 5'd21, w);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_result", out_result, 0);
        chk("midrst_out_tag", out_tag, 0);

        run_op("post_rst_divu", ALU_DIVU, 32'd100, 32'd7, 5'd22, 32'd14, 33);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
`default_nettype wire
